// File: rtl/fv_fetch_sequencer.sv
// FV fetch sequencer: buffers FV descriptors and expands them into single-word SRAM reads
// feeding a 2-entry PE output buffer. Define FV_FETCH_OVF_CNT_EN to count dropped descriptor writes.
module fv_fetch_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 4,
    parameter int PE_ID_W = 2,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               info_valid,
    input  logic [ADDR_W-1:0]  info_base,
    input  logic [LEN_W-1:0]   info_len,
    input  logic [PE_ID_W-1:0] info_pe,
    output logic               fifo_full,
    output logic               sram_cen,
    output logic [ADDR_W-1:0]  sram_a,
    input  logic [DATA_W-1:0]  sram_q,
    output logic               pe_valid,
    input  logic               pe_ready,
    output logic [DATA_W-1:0]  pe_data,
    output logic [PE_ID_W-1:0] pe_id,
    output logic               pe_last,
    output logic               busy,
    output logic [7:0]         ovf_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [ADDR_W-1:0]  fifo_base [DEPTH];
    logic [LEN_W-1:0]   fifo_len  [DEPTH];
    logic [PE_ID_W-1:0] fifo_pe   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, count, count_next;
    logic [IDX_W-1:0]   head_idx;
    logic               fifo_empty, push, pop, head_nonzero;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   rem;
    logic [PE_ID_W-1:0] cur_pe;
    logic               infl, infl_last;
    logic [PE_ID_W-1:0] infl_pe;
    logic               issue, last_issue, credit, pe_pop;

    logic [DATA_W-1:0]  buf_data [2];
    logic [PE_ID_W-1:0] buf_id   [2];
    logic               buf_last [2];
    logic               buf_rd, buf_wr;
    logic [1:0]         occ;

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign push         = info_valid && !fifo_full;
    assign count        = wr_ptr - rd_ptr;
    assign count_next   = count + PTR_W'(push) - PTR_W'(pop);
    assign head_idx     = rd_ptr[IDX_W-1:0];
    assign head_nonzero = (fifo_len[head_idx] != '0);

    // Credit counts buffered words plus the read whose data is on sram_q this cycle.
    assign pe_pop     = pe_valid && pe_ready;
    assign credit     = ({1'b0, occ} + {2'b0, infl}) < (3'd2 + {2'b0, pe_pop});
    assign issue      = (state == ISSUE) && credit;
    assign last_issue = issue && (rem == LEN_W'(1));
    assign pop        = !fifo_empty && ((state == IDLE) || last_issue);

    assign sram_cen = !issue;
    assign sram_a   = addr;
    assign pe_valid = (occ != 2'd0);
    assign pe_data  = buf_data[buf_rd];
    assign pe_id    = buf_id[buf_rd];
    assign pe_last  = buf_last[buf_rd];
    assign busy     = !fifo_empty || (state != IDLE) || infl || (occ != 2'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_base[wr_ptr[IDX_W-1:0]] <= info_base;
            fifo_len[wr_ptr[IDX_W-1:0]]  <= info_len;
            fifo_pe[wr_ptr[IDX_W-1:0]]   <= info_pe;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_full <= (count_next == PTR_W'(DEPTH));
        end
    end

    // A popped zero-length head is simply discarded; IDLE keeps popping one per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            cur_pe    <= '0;
            infl      <= 1'b0;
            infl_pe   <= '0;
            infl_last <= 1'b0;
        end else begin
            infl      <= issue;
            infl_pe   <= cur_pe;
            infl_last <= last_issue;
            if (issue) begin
                addr <= addr + ADDR_W'(1);
                rem  <= rem - LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    if (pop && head_nonzero) begin
                        addr   <= fifo_base[head_idx];
                        rem    <= fifo_len[head_idx];
                        cur_pe <= fifo_pe[head_idx];
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        if (pop && head_nonzero) begin
                            addr   <= fifo_base[head_idx];
                            rem    <= fifo_len[head_idx];
                            cur_pe <= fifo_pe[head_idx];
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_id[i]   <= '0;
                buf_last[i] <= 1'b0;
            end
            buf_rd <= 1'b0;
            buf_wr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (infl) begin
                buf_data[buf_wr] <= sram_q;
                buf_id[buf_wr]   <= infl_pe;
                buf_last[buf_wr] <= infl_last;
                buf_wr           <= ~buf_wr;
            end
            if (pe_pop) buf_rd <= ~buf_rd;
            occ <= occ + 2'(infl) - 2'(pe_pop);
        end
    end

`ifdef FV_FETCH_OVF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt <= 8'd0;
        end else if (info_valid && fifo_full && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`else
    assign ovf_cnt = 8'd0;
`endif

endmodule
